// File: rtl/rf_wb_sched_pkg.sv
// Shared constants for the register-file write-back scheduler.
// Also holds the source encoding used by the round-robin pointer.
package rf_wb_sched_pkg;

    localparam int unsigned DEF_AW = 5;
    localparam int unsigned DEF_DW = 32;
    localparam int unsigned NREG   = 2 ** DEF_AW;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy vector, set/clear, and RAW/WAW issue stall.
module rf_scoreboard
    import rf_wb_sched_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rs1,
    input  logic [AW-1:0]      issue_rs2,
    input  logic [AW-1:0]      issue_rd,
    input  logic               issue_rd_we,
    input  logic               clr_en,
    input  logic [AW-1:0]      clr_addr,
    output logic [2**AW-1:0]   busy,
    output logic               issue_stall
);

    localparam int unsigned NR = 2 ** AW;

    logic [NR-1:0] busy_d;
    logic          rs1_hit;
    logic          rs2_hit;
    logic          rd_hit;
    logic          set_en;

    // Hazard compare and next busy vector; a set overrides a same-register clear.
    always_comb begin
        rs1_hit     = (issue_rs1 != '0) && busy[issue_rs1];
        rs2_hit     = (issue_rs2 != '0) && busy[issue_rs2];
        rd_hit      = issue_rd_we && (issue_rd != '0) && busy[issue_rd];
        issue_stall = issue_valid && (rs1_hit || rs2_hit || rd_hit);
        set_en      = issue_valid && !issue_stall && issue_rd_we && (issue_rd != '0);

        busy_d = busy;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Write-back scheduler: round-robin ALU/load arbitration onto the single
// register-file write port, plus the hazard scoreboard that gates issue.
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               issue_valid,
    input  logic [AW-1:0]      issue_rs1,
    input  logic [AW-1:0]      issue_rs2,
    input  logic [AW-1:0]      issue_rd,
    input  logic               issue_rd_we,
    output logic               issue_stall,
    input  logic               alu_valid,
    input  logic [AW-1:0]      alu_rd,
    input  logic [DW-1:0]      alu_wd,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [AW-1:0]      mem_rd,
    input  logic [DW-1:0]      mem_wd,
    output logic               mem_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic [2**AW-1:0]   busy,
    output logic               wb_err
);

    src_e          last_q;
    src_e          last_d;
    logic          grant_alu_c;
    logic          grant_mem_c;
    logic          grant_c;
    logic [AW-1:0] g_rd_c;
    logic [DW-1:0] g_wd_c;
    logic          we_d;
    logic [AW-1:0] wa_d;
    logic [DW-1:0] wd_d;
    logic          err_d;

    rf_scoreboard #(
        .AW (AW)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_rd_we (issue_rd_we),
        .clr_en      (rf_we),
        .clr_addr    (rf_wa),
        .busy        (busy),
        .issue_stall (issue_stall)
    );

    // Round-robin: on a tie the source not granted last time wins.
    always_comb begin
        grant_alu_c = alu_valid && (!mem_valid || (last_q == SRC_MEM));
        grant_mem_c = mem_valid && !grant_alu_c;
        grant_c     = grant_alu_c || grant_mem_c;
        g_rd_c      = grant_alu_c ? alu_rd : mem_rd;
        g_wd_c      = grant_alu_c ? alu_wd : mem_wd;
    end

    assign alu_ready = grant_alu_c;
    assign mem_ready = grant_mem_c;

    // Next write-port state; x0 grants are consumed without a write.
    always_comb begin
        we_d   = 1'b0;
        wa_d   = rf_wa;
        wd_d   = rf_wd;
        err_d  = wb_err;
        last_d = last_q;
        if (grant_c) begin
            we_d   = (g_rd_c != '0);
            wa_d   = g_rd_c;
            wd_d   = g_wd_c;
            last_d = grant_alu_c ? SRC_ALU : SRC_MEM;
            if ((g_rd_c != '0) && !busy[g_rd_c]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            wb_err <= 1'b0;
            last_q <= SRC_MEM;
        end else begin
            rf_we  <= we_d;
            rf_wa  <= wa_d;
            rf_wd  <= wd_d;
            wb_err <= err_d;
            last_q <= last_d;
        end
    end

endmodule
